vdp_super_vram_arbiter: RTL and testbench

//  Slot-based arbiter for the single 32-bit VRAM port shared by super-res display fetch, CPU port and command engine.

---
 rtl/vdp_arb_pkg.sv | 27 ++
 rtl/vdp_arb_stats.sv | 42 ++++
 rtl/vdp_super_vram_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_vdp_super_vram_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_arb_pkg.sv
// Shared types for the super-res VRAM slot arbiter: grant owners, FSM states,
// slot alignment constant and the CPU byte-lane helper.
package vdp_arb_pkg;

   localparam int         ADDR_W           = 17;
   localparam logic [1:0] SLOT_ISSUE_PHASE = 2'd0;

   typedef enum logic [2:0] {
      GNT_NONE,
      GNT_REFRESH,
      GNT_DISP,
      GNT_CPU,
      GNT_CMD
   } gnt_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DATA
   } arb_state_t;

   // One-hot byte enable for a CPU byte access on a 32-bit word.
   function automatic logic [3:0] lane_be(input logic [1:0] lane);
      return 4'b0001 << lane;
   endfunction

endpackage

// File: rtl/vdp_arb_stats.sv
// Saturating slot statistics for the VRAM arbiter: display, CPU, command and
// empty slots. Only instantiated when VDP_ARB_STATS_EN is defined.
module vdp_arb_stats
   import vdp_arb_pkg::*;
#(
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stat_clr,
   input  logic              slot_tick,
   input  gnt_t              gnt,
   output logic [STAT_W-1:0] stat_disp,
   output logic [STAT_W-1:0] stat_cpu,
   output logic [STAT_W-1:0] stat_cmd,
   output logic [STAT_W-1:0] stat_idle
);

   // Refresh slots are not counted; they are not bandwidth anyone asked for.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_disp <= '0;
         stat_cpu  <= '0;
         stat_cmd  <= '0;
         stat_idle <= '0;
      end else if (stat_clr) begin
         stat_disp <= '0;
         stat_cpu  <= '0;
         stat_cmd  <= '0;
         stat_idle <= '0;
      end else if (slot_tick) begin
         case (gnt)
            GNT_DISP: if (~&stat_disp) stat_disp <= stat_disp + 1'b1;
            GNT_CPU:  if (~&stat_cpu)  stat_cpu  <= stat_cpu + 1'b1;
            GNT_CMD:  if (~&stat_cmd)  stat_cmd  <= stat_cmd + 1'b1;
            GNT_NONE: if (~&stat_idle) stat_idle <= stat_idle + 1'b1;
            default:  ;
         endcase
      end
   end

endmodule

// File: rtl/vdp_super_vram_arbiter.sv
// Slot arbiter for the shared 32-bit VRAM port: refresh > display (drawing window)
// > round-robin CPU/command, one access per 4-clk slot. VDP_ARB_STATS_EN adds slot counters.
module vdp_super_vram_arbiter
   import vdp_arb_pkg::*;
#(
   parameter int ADDR_W = vdp_arb_pkg::ADDR_W
`ifdef VDP_ARB_STATS_EN
   ,
   parameter int STAT_W = 16
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        slot_phase,
   input  logic              drawing,
   // Handshake: each req is a level held until its 1-clk ack (issued at phase 0 for
   // refresh, phase 1 otherwise); it must drop the clk after ack, else it is a new access.
   input  logic              refresh_req,
   output logic              refresh_ack,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_ack,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W+1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_ack,
   input  logic              cmd_req,
   input  logic              cmd_we,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [31:0]       cmd_wdata,
   input  logic [3:0]        cmd_be,
   output logic [31:0]       cmd_rdata,
   output logic              cmd_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   output logic              mem_we,
   output logic              mem_oe,
   output logic              mem_refresh,
   input  logic [31:0]       mem_rdata,
   output logic [1:0]        dbg_state
`ifdef VDP_ARB_STATS_EN
   ,
   input  logic              stat_clr,
   output logic [STAT_W-1:0] stat_disp,
   output logic [STAT_W-1:0] stat_cpu,
   output logic [STAT_W-1:0] stat_cmd,
   output logic [STAT_W-1:0] stat_idle
`endif
);

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_ISSUE = ISSUE;
   localparam logic [1:0] ST_DATA  = DATA;

   logic [1:0]  state_q;
   gnt_t        owner_q;
   logic        owner_we_q;
   logic [1:0]  owner_lane_q;
   logic        rr_cmd_q;
   logic [7:0]  cpu_rdata_q;
   logic [31:0] cmd_rdata_q;

   logic        slot_open;
   logic        issue;
   gnt_t        gnt;
   logic        in_data;
   logic        cpu_rd_done;
   logic        cmd_rd_done;
   logic [7:0]  cpu_lane_byte;

   // ISSUE lives only in the phase-0 cycle, so it is decoded rather than registered;
   // gating with reset keeps the strobes quiet while reset is held.
   always_comb begin
      slot_open = (state_q == ST_IDLE) && (slot_phase == SLOT_ISSUE_PHASE) && !reset;
      gnt       = GNT_NONE;
      if (refresh_req)               gnt = GNT_REFRESH;
      else if (drawing && disp_req)  gnt = GNT_DISP;
      else if (cpu_req && cmd_req)   gnt = rr_cmd_q ? GNT_CMD : GNT_CPU;
      else if (cpu_req)              gnt = GNT_CPU;
      else if (cmd_req)              gnt = GNT_CMD;
   end

   assign issue     = slot_open && (gnt != GNT_NONE);
   assign dbg_state = issue ? ST_ISSUE : state_q;

   always_comb begin
      mem_addr    = '0;
      mem_wdata   = '0;
      mem_be      = '0;
      mem_we      = 1'b0;
      mem_oe      = 1'b0;
      mem_refresh = 1'b0;
      refresh_ack = 1'b0;
      if (issue) begin
         case (gnt)
            GNT_REFRESH: begin
               mem_refresh = 1'b1;
               refresh_ack = 1'b1;
            end
            GNT_DISP: begin
               mem_addr = disp_addr;
               mem_oe   = 1'b1;
            end
            GNT_CPU: begin
               mem_addr = cpu_addr[ADDR_W+1:2];
               if (cpu_we) begin
                  mem_we    = 1'b1;
                  mem_wdata = {4{cpu_wdata}};
                  mem_be    = lane_be(cpu_addr[1:0]);
               end else begin
                  mem_oe = 1'b1;
               end
            end
            GNT_CMD: begin
               mem_addr = cmd_addr;
               if (cmd_we) begin
                  mem_we    = 1'b1;
                  mem_wdata = cmd_wdata;
                  mem_be    = cmd_be;
               end else begin
                  mem_oe = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_data       = (state_q == ST_DATA);
   assign disp_ack      = in_data && (owner_q == GNT_DISP);
   assign cpu_ack       = in_data && (owner_q == GNT_CPU);
   assign cmd_ack       = in_data && (owner_q == GNT_CMD);
   assign cpu_rd_done   = cpu_ack && !owner_we_q;
   assign cmd_rd_done   = cmd_ack && !owner_we_q;
   assign cpu_lane_byte = mem_rdata[8*owner_lane_q +: 8];

   // Read data is presented straight from VRAM during the ack clk, then held.
   assign cpu_rdata = cpu_rd_done ? cpu_lane_byte : cpu_rdata_q;
   assign cmd_rdata = cmd_rd_done ? mem_rdata : cmd_rdata_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         owner_q      <= GNT_NONE;
         owner_we_q   <= 1'b0;
         owner_lane_q <= 2'd0;
         rr_cmd_q     <= 1'b0;
         cpu_rdata_q  <= '0;
         cmd_rdata_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (issue && (gnt != GNT_REFRESH)) begin
                  state_q      <= ST_DATA;
                  owner_q      <= gnt;
                  owner_we_q   <= (gnt == GNT_CPU) ? cpu_we :
                                  (gnt == GNT_CMD) ? cmd_we : 1'b0;
                  owner_lane_q <= cpu_addr[1:0];
               end
            end
            // DATA always lasts exactly one clk, even if slot_phase jumped.
            default: begin
               state_q <= ST_IDLE;
               owner_q <= GNT_NONE;
            end
         endcase

         // The pointer only moves when the requester it favours is the one served.
         if (issue && (((gnt == GNT_CPU) && !rr_cmd_q) || ((gnt == GNT_CMD) && rr_cmd_q)))
            rr_cmd_q <= !rr_cmd_q;

         if (cpu_rd_done) cpu_rdata_q <= cpu_lane_byte;
         if (cmd_rd_done) cmd_rdata_q <= mem_rdata;
      end
   end

`ifdef VDP_ARB_STATS_EN
   vdp_arb_stats #(
      .STAT_W (STAT_W)
   ) u_stats (
      .clk       (clk),
      .reset     (reset),
      .stat_clr  (stat_clr),
      .slot_tick (slot_open),
      .gnt       (gnt),
      .stat_disp (stat_disp),
      .stat_cpu  (stat_cpu),
      .stat_cmd  (stat_cmd),
      .stat_idle (stat_idle)
   );
`else
`endif

endmodule

// File: tb/tb_vdp_super_vram_arbiter.sv
// Bench for vdp_super_vram_arbiter: directed slot scenarios then random slots,
// checked against a slot-level reference model that also plays the VRAM.
module tb_vdp_super_vram_arbiter;
   import vdp_arb_pkg::*;

   localparam int AW     = 17;
   localparam int W_NONE = 0;
   localparam int W_REF  = 1;
   localparam int W_DISP = 2;
   localparam int W_CPU  = 3;
   localparam int W_CMD  = 4;

   // ---------------- clock / reset / signals ----------------
   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    slot_phase;
   logic          drawing;
   logic          refresh_req;
   logic          refresh_ack;
   logic          disp_req;
   logic [AW-1:0] disp_addr;
   logic          disp_ack;
   logic          cpu_req;
   logic          cpu_we;
   logic [AW+1:0] cpu_addr;
   logic [7:0]    cpu_wdata;
   logic [7:0]    cpu_rdata;
   logic          cpu_ack;
   logic          cmd_req;
   logic          cmd_we;
   logic [AW-1:0] cmd_addr;
   logic [31:0]   cmd_wdata;
   logic [3:0]    cmd_be;
   logic [31:0]   cmd_rdata;
   logic          cmd_ack;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_be;
   logic          mem_we;
   logic          mem_oe;
   logic          mem_refresh;
   logic [31:0]   mem_rdata;
   logic [1:0]    dbg_state;

   always #5 clk = ~clk;

   vdp_super_vram_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .slot_phase  (slot_phase),
      .drawing     (drawing),
      .refresh_req (refresh_req),
      .refresh_ack (refresh_ack),
      .disp_req    (disp_req),
      .disp_addr   (disp_addr),
      .disp_ack    (disp_ack),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_rdata   (cpu_rdata),
      .cpu_ack     (cpu_ack),
      .cmd_req     (cmd_req),
      .cmd_we      (cmd_we),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .cmd_be      (cmd_be),
      .cmd_rdata   (cmd_rdata),
      .cmd_ack     (cmd_ack),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_be      (mem_be),
      .mem_we      (mem_we),
      .mem_oe      (mem_oe),
      .mem_refresh (mem_refresh),
      .mem_rdata   (mem_rdata),
      .dbg_state   (dbg_state)
   );

   // ---------------- scoreboard / reference model state ----------------
   int            total = 0;
   int            bad   = 0;
   bit            rr_cmd;
   logic [7:0]    last_cpu_rd;
   logic [31:0]   last_cmd_rd;
   logic [31:0]   vram [int];
   logic [2:0]    exp_q [$];
   int            n_disp, n_cpu, n_cmd;
   logic [AW-1:0] obs_addr;
   logic [3:0]    obs_be;
   logic [31:0]   obs_wdata;
   logic          obs_we;
   logic [7:0]    obs_cpu_rd;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] vram_rd(input logic [AW-1:0] a);
      if (!vram.exists(int'(a))) vram[int'(a)] = $urandom();
      return vram[int'(a)];
   endfunction

   // ---------------- driver: one full slot with model checks ----------------
   task automatic run_slot(input bit jump, output int w_obs);
      int            w;
      logic [AW-1:0] ea;
      logic [3:0]    ebe;
      logic [31:0]   ewd, rdv, word;
      logic          ewe, eoe;
      logic [1:0]    lane;
      w_obs = W_NONE;

      @(posedge clk); #1;
      slot_phase = 2'd0;
      mem_rdata  = $urandom();
      if (refresh_req)              w = W_REF;
      else if (drawing && disp_req) w = W_DISP;
      else if (cpu_req && cmd_req)  w = rr_cmd ? W_CMD : W_CPU;
      else if (cpu_req)             w = W_CPU;
      else if (cmd_req)             w = W_CMD;
      else                          w = W_NONE;
      if ((w == W_CPU && !rr_cmd) || (w == W_CMD && rr_cmd)) rr_cmd = !rr_cmd;
      ea = '0; ebe = '0; ewd = '0; ewe = 1'b0; eoe = 1'b0; lane = cpu_addr[1:0];
      case (w)
         W_DISP: begin ea = disp_addr; eoe = 1'b1; end
         W_CPU: begin
            ea = cpu_addr[AW+1:2];
            if (cpu_we) begin ewe = 1'b1; ebe = 4'b0001 << lane; ewd = {4{cpu_wdata}}; end
            else eoe = 1'b1;
         end
         W_CMD: begin
            ea = cmd_addr;
            if (cmd_we) begin ewe = 1'b1; ebe = cmd_be; ewd = cmd_wdata; end
            else eoe = 1'b1;
         end
         default: ;
      endcase
      @(negedge clk);
      check("p0_ctl", {dbg_state, mem_refresh, mem_oe, mem_we, refresh_ack, disp_ack, cpu_ack, cmd_ack},
            {(w == W_NONE) ? 2'(IDLE) : 2'(ISSUE), w == W_REF, eoe, ewe, w == W_REF, 3'b000});
      check("p0_addr_be", {mem_be, mem_addr}, {ebe, ea});
      check("p0_wdata", mem_wdata, ewd);
      obs_addr = mem_addr; obs_be = mem_be; obs_wdata = mem_wdata; obs_we = mem_we;
      if (refresh_ack) w_obs = W_REF;
      if (ewe) begin
         word = vram_rd(ea);
         for (int b = 0; b < 4; b++) if (ebe[b]) word[8*b +: 8] = ewd[8*b +: 8];
         vram[int'(ea)] = word;
      end

      @(posedge clk); #1;
      slot_phase = jump ? 2'd3 : 2'd1;
      if (w == W_REF) refresh_req = 1'b0;
      rdv       = eoe ? vram_rd(ea) : 32'($urandom());
      mem_rdata = rdv;
      @(negedge clk);
      check("p1_ack", {dbg_state, mem_refresh, mem_oe, mem_we, refresh_ack, disp_ack, cpu_ack, cmd_ack},
            {(w == W_DISP || w == W_CPU || w == W_CMD) ? 2'(DATA) : 2'(IDLE), 4'b0000,
             w == W_DISP, w == W_CPU, w == W_CMD});
      if (disp_ack) begin n_disp++; w_obs = W_DISP; end
      if (cpu_ack)  begin n_cpu++;  w_obs = W_CPU;  end
      if (cmd_ack)  begin n_cmd++;  w_obs = W_CMD;  end
      if (w == W_CPU && eoe) last_cpu_rd = rdv[8*lane +: 8];
      if (w == W_CMD && eoe) last_cmd_rd = rdv;
      check("p1_rdata", {cpu_rdata, cmd_rdata}, {last_cpu_rd, last_cmd_rd});
      obs_cpu_rd = cpu_rdata;

      @(posedge clk); #1;
      slot_phase = 2'd2;
      mem_rdata  = $urandom();
      if (w == W_CPU) cpu_req = 1'b0;
      if (w == W_CMD) cmd_req = 1'b0;
      @(negedge clk);
      check("p2_hold", {dbg_state, mem_oe, mem_we, mem_refresh, disp_ack, cpu_ack, cmd_ack, cpu_rdata, cmd_rdata},
            {2'(IDLE), 6'b000000, last_cpu_rd, last_cmd_rd});
      if (!jump) begin
         @(posedge clk); #1;
         slot_phase = 2'd3;
      end
   endtask

   // ---------------- directed steps, random slots, report ----------------
   initial begin
      int w, n0d, n0c;
      reset = 1'b1; slot_phase = 2'd0; drawing = 1'b0; refresh_req = 1'b1;
      disp_req = 1'b0; disp_addr = '0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0;
      cpu_wdata = '0; cmd_req = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      cmd_be = '0; mem_rdata = 32'hDEADBEEF;
      rr_cmd = 1'b0; last_cpu_rd = '0; last_cmd_rd = '0; n_disp = 0; n_cpu = 0; n_cmd = 0;

      // Reset state, with requests present at phase 0.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ctl", {refresh_ack, disp_ack, cpu_ack, cmd_ack, mem_we, mem_oe, mem_refresh,
                          mem_be, dbg_state, cpu_rdata}, '0);
      check("reset_bus", {mem_addr, mem_wdata}, '0);
      check("reset_cmd_rdata", cmd_rdata, '0);
      @(posedge clk); #1;
      reset = 1'b0; refresh_req = 1'b0; cpu_req = 1'b0; slot_phase = 2'd3;

      // Round-robin from reset: CPU, CMD, CPU, CMD.
      exp_q = '{3'(W_CPU), 3'(W_CMD), 3'(W_CPU), 3'(W_CMD)};
      cpu_we = 1'b0; cpu_addr = 19'h00011; cmd_we = 1'b1; cmd_addr = 17'h00008;
      cmd_wdata = 32'hCAFE0123; cmd_be = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         cpu_req = 1'b1; cmd_req = 1'b1;
         run_slot(1'b0, w);
         check("rr_order", w, exp_q.pop_front());
      end
      cpu_req = 1'b0; cmd_req = 1'b0;

      // Display owns slots in the drawing window; CPU starves until drawing drops.
      drawing = 1'b1; disp_req = 1'b1; disp_addr = 17'h1ABCD;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00040;
      n0d = n_disp; n0c = n_cpu;
      repeat (8) run_slot(1'b0, w);
      check("disp_8_slots", n_disp - n0d, 8);
      check("cpu_starved", n_cpu - n0c, 0);
      drawing = 1'b0;
      run_slot(1'b0, w);
      check("cpu_after_draw", w, W_CPU);
      disp_req = 1'b0;

      // Refresh beats display, display follows in the next slot.
      refresh_req = 1'b1; drawing = 1'b1; disp_req = 1'b1;
      run_slot(1'b0, w);
      check("refresh_first", w, W_REF);
      run_slot(1'b0, w);
      check("disp_after_refresh", w, W_DISP);
      drawing = 1'b0; disp_req = 1'b0;

      // CPU byte write lane placement.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00006; cpu_wdata = 8'hA5;
      run_slot(1'b0, w);
      check("wr_grant", w, W_CPU);
      check("wr_addr", obs_addr, 17'h00001);
      check("wr_be", obs_be, 4'b0100);
      check("wr_wdata", obs_wdata, 32'hA5A5A5A5);
      check("wr_we", obs_we, 1'b1);

      // CPU byte read picks lane 3.
      vram[0] = 32'h11223344;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00003;
      run_slot(1'b0, w);
      check("rd_grant", w, W_CPU);
      check("rd_byte", obs_cpu_rd, 8'h11);

      // Timing reset while in DATA: the slot still completes.
      cmd_req = 1'b1; cmd_we = 1'b0; cmd_addr = 17'h00001;
      run_slot(1'b1, w);
      check("jump_cmd_ack", w, W_CMD);

      // Reset during ISSUE aborts the slot; the request is served after release.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00005;
      @(posedge clk); #1;
      slot_phase = 2'd0;
      #2 reset = 1'b1;
      @(negedge clk);
      check("abort_p0", {refresh_ack, disp_ack, cpu_ack, cmd_ack, mem_we, mem_oe, mem_refresh,
                         mem_be, dbg_state, cpu_rdata, mem_addr}, '0);
      check("abort_p0_data", {mem_wdata, cmd_rdata}, '0);
      @(posedge clk); #1;
      slot_phase = 2'd1;
      @(negedge clk);
      check("abort_no_ack", {disp_ack, cpu_ack, cmd_ack, dbg_state}, '0);
      @(posedge clk); #1;
      slot_phase = 2'd2; reset = 1'b0;
      rr_cmd = 1'b0; last_cpu_rd = '0; last_cmd_rd = '0;
      @(posedge clk); #1;
      slot_phase = 2'd3;
      run_slot(1'b0, w);
      check("retry_after_reset", w, W_CPU);

      // Random traffic against the model.
      for (int s = 0; s < 150; s++) begin
         drawing   = 1'($urandom_range(0, 1));
         disp_req  = 1'($urandom_range(0, 1));
         disp_addr = 17'($urandom());
         if (!refresh_req && $urandom_range(0, 7) == 0) refresh_req = 1'b1;
         if (!cpu_req && $urandom_range(0, 2) != 0) begin
            cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
            cpu_addr = 19'($urandom_range(0, 63)); cpu_wdata = 8'($urandom());
         end
         if (!cmd_req && $urandom_range(0, 2) != 0) begin
            cmd_req = 1'b1; cmd_we = 1'($urandom_range(0, 1));
            cmd_addr = 17'($urandom_range(0, 15)); cmd_wdata = $urandom();
            cmd_be = 4'($urandom());
         end
         run_slot(($urandom_range(0, 15) == 0), w);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
